// File: rtl/div_pkg.sv
// div_pkg: shared state codes, handshake levels and ALU op codes for the divider
package div_pkg;
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;
  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;
  localparam int   DOUBLE_REG_W         = 64;
  localparam logic [7:0] EXE_DIV_OP     = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP    = 8'b0001_1011;
endpackage

// File: rtl/div_step.sv
// div_step: one restoring subtract-and-shift step on the working dividend register
module div_step
  import div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2*DATA_W:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [2*DATA_W:0] dividend_o
);
  logic [DATA_W:0] diff;
  // a borrow out of the top bit means the partial remainder is below the divisor
  always_comb begin
    diff       = dividend_i[2*DATA_W:DATA_W] - {1'b0, divisor_i};
    dividend_o = diff[DATA_W] ? {dividend_i[2*DATA_W-1:0], 1'b0}
                              : {diff[DATA_W-1:0], dividend_i[DATA_W-1:0], 1'b1};
  end
endmodule

// File: rtl/div.sv
// div: multi-cycle radix-2 restoring divider for DIV/DIVU; DIV_EARLY_EXIT_EN skips the loop when |op1| < |op2|
module div
  import div_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);
  localparam int CW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] CNT_DONE = CW'(DATA_W);
  div_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2*DATA_W:0] dividend_q, dividend_d, step_next;
  logic [DATA_W-1:0] divisor_q, divisor_d;
  logic sign1_q, sign1_d, sign2_q, sign2_d, signed_q, signed_d;
  logic [2*DATA_W-1:0] result_q, result_d;
  logic ready_q, ready_d;
  logic neg1, neg2;
  logic [DATA_W-1:0] abs1, abs2, quo, rem;
  div_step #(.DATA_W(DATA_W)) u_step (
    .dividend_i(dividend_q),
    .divisor_i (divisor_q),
    .dividend_o(step_next)
  );
  // operand magnitudes and sign-corrected final quotient/remainder
  always_comb begin
    neg1 = signed_div_i & opdata1_i[DATA_W-1];
    neg2 = signed_div_i & opdata2_i[DATA_W-1];
    abs1 = neg1 ? -opdata1_i : opdata1_i;
    abs2 = neg2 ? -opdata2_i : opdata2_i;
    quo  = dividend_q[DATA_W-1:0];
    rem  = dividend_q[2*DATA_W:DATA_W+1];
    quo  = (signed_q & (sign1_q ^ sign2_q)) ? -quo : quo;
    rem  = (signed_q & sign1_q) ? -rem : rem;
  end
  // next-state logic; outputs are registered and only non-zero on entry to or while in END
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    sign1_d    = sign1_q;
    sign2_d    = sign2_q;
    signed_d   = signed_q;
    ready_d    = DIV_RESULT_NOT_READY;
    result_d   = '0;
    case (state_q)
      DIV_FREE: begin
        if (start_i == DIV_START && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DIV_BY_ZERO;
          end
`ifdef DIV_EARLY_EXIT_EN
          else if (abs1 < abs2) begin
            state_d  = DIV_END;
            ready_d  = DIV_RESULT_READY;
            result_d = {opdata1_i, {DATA_W{1'b0}}};
          end
`endif
          else begin
            state_d    = DIV_ON;
            cnt_d      = '0;
            dividend_d = {{DATA_W{1'b0}}, abs1, 1'b0};
            divisor_d  = abs2;
            sign1_d    = neg1;
            sign2_d    = neg2;
            signed_d   = signed_div_i;
          end
        end
      end
      DIV_BY_ZERO: begin
        state_d = DIV_END;
        ready_d = DIV_RESULT_READY;
      end
      DIV_ON: begin
        if (annul_i) begin
          state_d = DIV_FREE;
        end else if (cnt_q != CNT_DONE) begin
          dividend_d = step_next;
          cnt_d      = cnt_q + CW'(1);
        end else begin
          state_d  = DIV_END;
          ready_d  = DIV_RESULT_READY;
          result_d = {rem, quo};
        end
      end
      default: begin
        state_d  = start_i == DIV_START ? DIV_END : DIV_FREE;
        ready_d  = start_i == DIV_START ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
        result_d = start_i == DIV_START ? result_q : '0;
      end
    endcase
  end
  // state and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      signed_q   <= 1'b0;
      result_q   <= '0;
      ready_q    <= DIV_RESULT_NOT_READY;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      sign1_q    <= sign1_d;
      sign2_q    <= sign2_d;
      signed_q   <= signed_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end
  assign result_o = result_q;
  assign ready_o  = ready_q;
endmodule

// File: tb/tb_div.sv
// tb_div: vector table, corner sequences and randomized checks of div against an arithmetic model
module tb_div;
`ifdef DIV_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic start_i = 1'b0;
  logic annul_i = 1'b0;
  logic [63:0] result_o;
  logic ready_o;
  int total = 0;
  int bad = 0;
  div #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
    .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    int          lat;
  } vec_t;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic longint mag(input logic s, input logic [31:0] x);
    return (s && x[31]) ? -longint'(signed'(x)) : longint'(x);
  endfunction
  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, q, r;
    if (b == 0) return 64'd0;
    ua = mag(s, a);
    ub = mag(s, b);
    q = ua / ub;
    r = ua % ub;
    if ((s && a[31]) != (s && b[31])) q = -q;
    if (s && a[31]) r = -r;
    return {r[31:0], q[31:0]};
  endfunction
  function automatic int model_lat(input logic s, input logic [31:0] a, input logic [31:0] b);
    if (b == 0) return 2;
    if (EE && mag(s, a) < mag(s, b)) return 1;
    return 34;
  endfunction
  // start at a negedge, count rising edges until ready, check, then drop start
  task automatic run_div(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_res, input int exp_lat);
    int n = 0;
    signed_div_i = s;
    opdata1_i = a;
    opdata2_i = b;
    start_i = 1'b1;
    while (n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ready_o) break;
      opdata1_i = $urandom;
      opdata2_i = $urandom;
      signed_div_i = 1'($urandom);
    end
    chk({name, " latency"}, 64'(n), 64'(exp_lat));
    chk({name, " result"}, result_o, exp_res);
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({name, " drop"}, {63'd0, ready_o} | result_o, 64'd0);
  endtask
  vec_t vt[8];
  initial begin
    vt[0] = '{1'b0, 32'd7, 32'd2, 64'h00000001_00000003, 34};
    vt[1] = '{1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34};
    vt[2] = '{1'b0, 32'd5, 32'd0, 64'h0, 2};
    vt[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34};
    vt[4] = '{1'b0, 32'd3, 32'd10, 64'h00000003_00000000, EE ? 1 : 34};
    vt[5] = '{1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34};
    vt[6] = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 64'hFFFFFFFF_00000003, 34};
    vt[7] = '{1'b1, 32'hFFFFFFFD, 32'd10, 64'hFFFFFFFD_00000000, EE ? 1 : 34};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset state", {63'd0, ready_o} | result_o, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) run_div($sformatf("vec%0d", i), vt[i].s, vt[i].a, vt[i].b, vt[i].res, vt[i].lat);
    signed_div_i = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("pre-annul ready", 64'(ready_o), 64'd0);
    end
    annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    annul_i = 1'b0;
    chk("annul outputs", {63'd0, ready_o} | result_o, 64'd0);
    run_div("after annul", 1'b0, 32'd100, 32'd3, 64'h00000001_00000021, 34);
    start_i = 1'b1;
    annul_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i % 10 == 9) chk("annul with start", 64'(ready_o), 64'd0);
    end
    start_i = 1'b0;
    annul_i = 1'b0;
    @(negedge clk);
    opdata1_i = 32'd1000;
    opdata2_i = 32'd7;
    start_i = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start_i = 1'b0;
    chk("mid reset", {63'd0, ready_o} | result_o, 64'd0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("post reset idle", 64'(ready_o), 64'd0);
    for (int i = 0; i < 30; i++) begin
      logic s;
      logic [31:0] a, b;
      s = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 15));
        1: b = a >> $urandom_range(0, 31);
        2: b = -32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      run_div($sformatf("rand%0d", i), s, a, b, model(s, a, b), model_lat(s, a, b));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div.md
Name: div

Overview:
- Multi-cycle radix-2 restoring divider used by the EX stage for DIV/DIVU.
- EX issues operands with a start request and stalls the pipeline until ready_o.
- EX then drives result_o into its HI/LO write request: HI = remainder, LO = quotient.
- Sits beside EX; consumes EX's request and feeds back the 64-bit HILO value.

Parameters:
- DATA_W, 32, operand width; result is 2*DATA_W, iteration counter is clog2(DATA_W)+1 bits.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset (rst == `RstEnable)
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  DATA_W  dividend
- opdata2_i  in  DATA_W  divisor
- start_i  in  1  `DivStart request; held high by EX until it has seen ready_o
- annul_i  in  1  cancel in-flight or requested division (branch/exception flush)
- result_o  out  2*DATA_W  {remainder, quotient}, registered
- ready_o  out  1  `DivResultReady when result_o valid, registered

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (any state, including mid-division): state=FREE, cnt=0, ready_o=0, result_o=0.
- States are FREE, BYZERO, ON and END.
- FREE:
  - start_i=1, annul_i=0, opdata2_i==0 -> BYZERO.
  - start_i=1, annul_i=0, otherwise -> ON. Latch |opdata1_i|, |opdata2_i| (two's-complement negate when signed_div_i and MSB set), the sign flags and signed_div_i. Set dividend register = {DATA_W'0, |op1|, 1'b0} (2*DATA_W+1 bits) and cnt=0.
  - Otherwise stay in FREE with ready_o=0 and result_o=0.
- BYZERO: next state END with result register = 0.
- ON, annul_i=1: -> FREE, ready_o=0, result_o=0.
- ON, cnt<DATA_W, one step per cycle:
  - diff = dividend[2W:W] - {1'b0, divisor}.
  - diff negative: dividend = dividend << 1 (LSB 0).
  - Otherwise: dividend = {diff[W-1:0], dividend[W-1:0], 1'b1}.
  - cnt++.
- ON, cnt==DATA_W (fixup):
  - q = dividend[W-1:0], r = dividend[2W:W+1].
  - Negate q if signed && (sign1 ^ sign2).
  - Negate r if signed && sign1.
  - -> END.
- END: ready_o=1, result_o={r,q}. Hold while start_i=1. When start_i=0 -> FREE; ready_o and result_o return to 0 in the same cycle.
- Inputs are sampled only in FREE; operand changes in ON/BYZERO/END are ignored.
- Latency with start accepted in cycle 0:
  - Normal division: ready_o is high from cycle DATA_W+2 (34 for DATA_W=32).
  - Divide-by-zero: ready_o is high from cycle 2.
- Overflow case 0x80000000 / -1 signed: quotient wraps to 0x80000000, remainder 0. No trap.
- annul_i in END: ignored; EX drops start_i.
- annul_i together with start_i in FREE: request rejected.

Optional Feature:
- DIV_EARLY_EXIT_EN defined: in FREE, if divisor != 0 and |op1| < |op2|, go directly to END with result_o = {opdata1_i, 0}. The remainder keeps the dividend's original signed value; ready_o is high in cycle 1.
- Undefined: every non-zero-divisor operation takes the full DATA_W+2 latency. Results are identical either way.

Decomposition:
- Shared defines file gets:
  - State codes DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11.
  - DivResultReady/DivResultNotReady, DivStart/DivStop.
  - `DoubleRegBus` is reused.
  - New EXE_DIV_OP/EXE_DIVU_OP aluop codes.
- One natural sub-module: div_step, the combinational subtract-and-shift producing the next dividend register. Sign/abs logic stays inline.

Test Plan:
- DIVU 7/2, start held, annul 0 -> ready_o rises cycle 34, result_o=64'h00000001_00000003; start_i dropped -> ready_o=0, result_o=0 next cycle.
- DIV -7 (0xFFFFFFF9) / 2 -> result_o=64'hFFFFFFFF_FFFFFFFD at cycle 34.
- DIVU 5/0 -> ready_o high cycle 2, result_o=0.
- DIV 0x80000000 / 0xFFFFFFFF -> result_o=64'h00000000_80000000.
- Start 100/3, assert annul_i cycle 10 -> FREE, ready_o never asserted. Immediate new 100/3 -> result {1, 33} at cycle 34 after its start. Also rst pulse at cycle 20 of another divide -> outputs 0 next cycle.
- DIVU 3/10 -> with DIV_EARLY_EXIT_EN ready_o cycle 1, result {3,0}; without the macro ready_o cycle 34, same result.
